// File: rtl/systolic_feed_scheduler_pkg.sv
// Shared constants and types for the systolic operand feed scheduler.
//   N_LANES / DEPTH / SKEW : array edge geometry and diagonal skew
//   DRAIN_CYCLES           : cycles after the last feed until results are final
//   T_FEED                 : length of the feed phase in unstalled cycles
//   SEL_W, T_W, D_W, LANE_W: derived field widths
//   state_t                : scheduler FSM state encoding
package systolic_pkg;

  localparam int unsigned N_LANES      = 4;
  localparam int unsigned DEPTH        = 4;
  localparam int unsigned SKEW         = 1;
  localparam int unsigned DRAIN_CYCLES = 2 * N_LANES - 1;
  localparam int unsigned SEL_W        = $clog2(DEPTH);
  localparam int unsigned T_FEED       = DEPTH + SKEW * (N_LANES - 1);
  localparam int unsigned T_W          = $clog2(T_FEED + 1);
  localparam int unsigned D_W          = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned LANE_W       = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/systolic_feed_scheduler_skew_lane_decode.sv
// Per-lane decode of the shared feed counter into a mux select and valid.
//   t         : feed counter value to decode
//   lane      : index of this lane (tied to a constant by the parent)
//   lane_en_c : lane carries valid data for this t
//   sel_c     : operand index for this lane (0 when inactive)
module skew_lane_decode
  import systolic_pkg::*;
(
  input  logic [T_W-1:0]    t,
  input  logic [LANE_W-1:0] lane,
  output logic              lane_en_c,
  output logic [SEL_W-1:0]  sel_c
);

  logic [31:0] first_t;
  logic [31:0] rel_t;

  // Lane i walks 0..DEPTH-1 starting SKEW*i cycles after lane 0.
  always_comb begin
    first_t   = SKEW * 32'(lane);
    rel_t     = 32'(t) - first_t;
    lane_en_c = 1'b0;
    sel_c     = '0;
    if ((32'(t) >= first_t) && (rel_t < DEPTH)) begin
      lane_en_c = 1'b1;
      sel_c     = SEL_W'(rel_t);
    end
  end

endmodule

// File: rtl/systolic_feed_scheduler.sv
// Sequences the operand mux bank on one edge of the systolic matmul array:
// a skewed feed phase, a drain phase, then a one-cycle done pulse.
//   clk, rst_n : clock and asynchronous active-low reset
//   start      : one-cycle request to begin a pass
//   stall      : freezes sequencing in FEED/DRAIN
//   busy       : pass in progress (FEED entry through DONE)
//   done       : one-cycle completion pulse
//   acc_clr    : one-cycle accumulator clear on the first FEED cycle
//   lane_en    : per-lane data valid
//   sel        : packed per-lane mux selects, lane i at [i*SEL_W +: SEL_W]
// Build option: SCHED_BACK2BACK_EN lets a start seen in DONE go straight to FEED.
module systolic_feed_scheduler
  import systolic_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stall,
  output logic                     busy,
  output logic                     done,
  output logic                     acc_clr,
  output logic [N_LANES-1:0]       lane_en,
  output logic [N_LANES*SEL_W-1:0] sel
);

  state_t                   state_q, state_d;
  logic [T_W-1:0]           t_q, t_d;
  logic [D_W-1:0]           d_q, d_d;
  logic                     hold_d;
  logic                     clr_d;

  logic                     busy_d, done_d;
  logic [N_LANES-1:0]       lane_en_d;
  logic [N_LANES*SEL_W-1:0] sel_d;

  logic [N_LANES-1:0]       dec_en;
  logic [SEL_W-1:0]         dec_sel [N_LANES];

  // Decode the upcoming counter value so the outputs can be registered.
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    skew_lane_decode u_dec (
      .t         (t_d),
      .lane      (LANE_W'(i)),
      .lane_en_c (dec_en[i]),
      .sel_c     (dec_sel[i])
    );
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      d_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      acc_clr <= 1'b0;
      lane_en <= '0;
      sel     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      d_q     <= d_d;
      busy    <= busy_d;
      done    <= done_d;
      acc_clr <= clr_d;
      lane_en <= lane_en_d;
      sel     <= sel_d;
    end
  end

  // Next state and counters; counters only advance below their terminal value.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    d_d     = d_q;
    hold_d  = 1'b0;
    clr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FEED;
          t_d     = '0;
          clr_d   = 1'b1;
        end
      end
      FEED: begin
        if (stall) begin
          hold_d = 1'b1;
        end else if (t_q == T_W'(T_FEED - 1)) begin
          state_d = DRAIN;
          d_d     = '0;
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      DRAIN: begin
        if (stall) begin
          hold_d = 1'b1;
        end else if (d_q == D_W'(DRAIN_CYCLES - 1)) begin
          state_d = DONE;
        end else begin
          d_d = d_q + D_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef SCHED_BACK2BACK_EN
        if (start) begin
          state_d = FEED;
          t_d     = '0;
          clr_d   = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming cycle; a stalled feed cycle keeps sel but drops valid.
  always_comb begin
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    lane_en_d = '0;
    sel_d     = '0;
    if (state_d == FEED) begin
      for (int i = 0; i < N_LANES; i++) begin
        lane_en_d[i]             = dec_en[i] & ~hold_d;
        sel_d[i*SEL_W +: SEL_W]  = dec_sel[i];
      end
    end
  end

endmodule

// File: tb/tb_systolic_feed_scheduler.sv
// Self-checking bench for systolic_feed_scheduler: directed scenarios plus
// randomized start/stall/reset against a progress-count reference model.
module tb_systolic_feed_scheduler;

  localparam int NL = 4;
  localparam int DP = 4;
  localparam int SK = 1;
  localparam int DR = 7;
  localparam int SW = 2;
  localparam int TF = DP + SK * (NL - 1);
`ifdef SCHED_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic          clk, rst_n, start, stall;
  logic          busy, done, acc_clr;
  logic [NL-1:0] lane_en;
  logic [NL*SW-1:0] sel;

  systolic_feed_scheduler dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stall   (stall),
    .busy    (busy),
    .done    (done),
    .acc_clr (acc_clr),
    .lane_en (lane_en),
    .sel     (sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_at  = -1;

  // Model: a pass is a progress count p of unstalled cycles since FEED entry.
  bit m_active, m_held, m_first, m_done;
  int m_p;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic void model_reset();
    m_active = 0; m_held = 0; m_first = 0; m_done = 0; m_p = 0;
  endfunction

  function automatic void model_begin();
    m_active = 1; m_p = 0; m_first = 1; m_held = 0;
  endfunction

  function automatic void model_step(input bit st, input bit sl);
    if (m_done) begin
      m_done = 0; m_active = 0; m_first = 0;
      if (B2B && st) model_begin();
    end else if (!m_active) begin
      m_first = 0;
      if (st) model_begin();
    end else begin
      m_first = 0;
      if (sl) m_held = 1;
      else begin
        m_held = 0;
        m_p++;
        if (m_p == TF + DR) m_done = 1;
      end
    end
  endfunction

  function automatic logic [NL-1:0] exp_en();
    logic [NL-1:0] r = '0;
    for (int i = 0; i < NL; i++)
      if (m_active && m_p < TF && !m_held && m_p >= SK*i && m_p < SK*i + DP) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [NL*SW-1:0] exp_sel();
    logic [NL*SW-1:0] r = '0;
    for (int i = 0; i < NL; i++)
      if (m_active && m_p < TF && m_p >= SK*i && m_p < SK*i + DP) r[i*SW +: SW] = SW'(m_p - SK*i);
    return r;
  endfunction

  task automatic check_all();
    check("busy",    32'(busy),    32'(m_active));
    check("done",    32'(done),    32'(m_done));
    check("acc_clr", 32'(acc_clr), 32'(m_first));
    check("lane_en", 32'(lane_en), 32'(exp_en()));
    check("sel",     32'(sel),     32'(exp_sel()));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(start, stall);
    #1;
    cyc++;
    if (done === 1'b1) begin
      done_cnt++;
      done_at = cyc;
    end
    check_all();
  endtask

  // Assert reset between edges, check outputs clear at once, hold across one edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic new_pass();
    start = 1'b1; cyc = 0; done_cnt = 0; done_at = -1;
    tick();
    start = 1'b0;
  endtask

  int busy_low;

  initial begin
    rst_n = 1'b0; start = 1'b1; stall = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (3) tick();
    rst_n = 1'b1;
    start = 1'b0;
    done_cnt = 0;
    repeat (4) tick();
    check("idle_after_reset_done", 32'(done_cnt), 32'd0);

    // Single clean pass.
    new_pass();
    repeat (16) tick();
    check("single_done_cycle", 32'(done_at), 32'd15);
    check("single_done_count", 32'(done_cnt), 32'd1);

    // Stall for three cycles once t=2 is shown.
    new_pass();
    tick(); tick();
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    for (int k = 0; k < 30 && done_cnt == 0; k++) tick();
    check("stall_done_cycle", 32'(done_at), 32'd18);
    repeat (2) tick();

    // Starts during FEED and DRAIN are ignored.
    new_pass();
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    check("ignored_start_done_count", 32'(done_cnt), 32'd1);
    check("ignored_start_done_cycle", 32'(done_at), 32'd15);

    // Start held through DONE.
    start = 1'b1; cyc = 0; busy_low = 0;
    for (int k = 0; k < 34; k++) begin
      tick();
      if (busy === 1'b0) busy_low++;
    end
    check("held_start_busy_low", 32'(busy_low), B2B ? 32'd0 : 32'd2);
    start = 1'b0;
    repeat (20) tick();

    // Reset in the third DRAIN cycle, then a clean pass.
    new_pass();
    repeat (9) tick();
    async_reset();
    repeat (8) tick();
    check("reset_no_done", 32'(done_cnt), 32'd0);
    new_pass();
    repeat (16) tick();
    check("post_reset_done_cycle", 32'(done_at), 32'd15);
    check("post_reset_done_count", 32'(done_cnt), 32'd1);

    // Randomized start/stall with occasional reset.
    for (int k = 0; k < 600; k++) begin
      start = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) async_reset();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
